// File: rtl/hb_chain_ctrl.sv
// Sequencer/router for a cascade of up to NSTG half-band decimators: flushes the
// delay lines with zeros, discards settling outputs, then forwards the last active stage.
module hb_chain_ctrl #(
    parameter int DW        = 35,
    parameter int NSTG      = 3,
    parameter int FLUSH_LEN = 64
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                cfg_en,
    input  logic [1:0]          cfg_nstage,
    input  logic [7:0]          cfg_settle,
    input  logic                cic_vld,
    input  logic [DW-1:0]       cic_dat,
    output logic [NSTG-1:0]     s_vld_in,
    output logic [NSTG*DW-1:0]  s_dat_in,
    input  logic [NSTG-1:0]     s_vld_out,
    input  logic [NSTG*DW-1:0]  s_dat_out,
    output logic                vld_out,
    output logic [DW-1:0]       dat_out,
    output logic                busy,
    output logic [1:0]          state
);

    localparam int FCW = $clog2(FLUSH_LEN + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_FLUSH  = 2'b01,
        ST_SETTLE = 2'b10,
        ST_RUN    = 2'b11
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        n_q, n_d;
    logic [7:0]        settle_q, settle_d;
    logic [FCW-1:0]    flush_cnt_q, flush_cnt_d;
    logic [7:0]        settle_cnt_q, settle_cnt_d;
    logic              vld_out_q, vld_out_d;
    logic [DW-1:0]     dat_out_q, dat_out_d;

    logic [NSTG-1:0]   act;
    logic              fin_vld;
    logic [DW-1:0]     fin_dat;
    logic [FCW-1:0]    flush_inc;
    logic [7:0]        settle_inc;

    always_comb begin
        for (int k = 0; k < NSTG; k++) begin
            act[k] = (state_q != ST_IDLE) && (k < int'(n_q));
        end
    end

    // Stage 0 sees zeros during FLUSH; later stages chain off the previous stage.
    always_comb begin
        s_vld_in = '0;
        s_dat_in = '0;
        s_vld_in[0] = cic_vld && act[0];
        s_dat_in[DW-1:0] = (state_q == ST_FLUSH) ? '0 : cic_dat;
        for (int k = 1; k < NSTG; k++) begin
            s_vld_in[k] = s_vld_out[k-1] && act[k];
            s_dat_in[k*DW +: DW] = s_dat_out[(k-1)*DW +: DW];
        end
    end

    always_comb begin
        fin_vld = cic_vld;
        fin_dat = cic_dat;
        for (int k = 0; k < NSTG; k++) begin
            if (int'(n_q) == k + 1) begin
                fin_vld = s_vld_out[k];
                fin_dat = s_dat_out[k*DW +: DW];
            end
        end
    end

    assign flush_inc  = flush_cnt_q + FCW'(1);
    assign settle_inc = settle_cnt_q + 8'd1;

    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        settle_d     = settle_q;
        flush_cnt_d  = flush_cnt_q;
        settle_cnt_d = settle_cnt_q;
        vld_out_d    = 1'b0;
        dat_out_d    = dat_out_q;

        case (state_q)
            ST_IDLE: begin
                if (cfg_en) begin
                    n_d          = cfg_nstage;
                    settle_d     = cfg_settle;
                    flush_cnt_d  = '0;
                    settle_cnt_d = '0;
                    state_d      = (cfg_nstage == 2'd0) ? ST_RUN : ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (cic_vld) begin
                    flush_cnt_d = flush_inc;
                    if (flush_inc == FCW'(FLUSH_LEN)) begin
                        state_d = (settle_q == 8'd0) ? ST_RUN : ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                if (fin_vld) begin
                    settle_cnt_d = settle_inc;
                    if (settle_inc == settle_q) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (fin_vld) begin
                    vld_out_d = 1'b1;
                    dat_out_d = fin_dat;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Stop wins over every other transition out of a busy state.
        if (state_q != ST_IDLE && !cfg_en) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            n_q          <= '0;
            settle_q     <= '0;
            flush_cnt_q  <= '0;
            settle_cnt_q <= '0;
            vld_out_q    <= 1'b0;
            dat_out_q    <= '0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            settle_q     <= settle_d;
            flush_cnt_q  <= flush_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            vld_out_q    <= vld_out_d;
            dat_out_q    <= dat_out_d;
        end
    end

    assign vld_out = vld_out_q;
    assign dat_out = dat_out_q;
    assign busy    = (state_q != ST_IDLE);
    assign state   = state_q;

endmodule

// File: tb/tb_hb_chain_ctrl.sv
// Directed bench for hb_chain_ctrl with simple pass-through decimate-by-2 stage models.
module tb_hb_chain_ctrl;

    localparam int DW   = 35;
    localparam int NSTG = 3;

    logic                clk;
    logic                rstn;
    logic                cfg_en;
    logic [1:0]          cfg_nstage;
    logic [7:0]          cfg_settle;
    logic                cic_vld;
    logic [DW-1:0]       cic_dat;
    logic [NSTG-1:0]     s_vld_in;
    logic [NSTG*DW-1:0]  s_dat_in;
    logic [NSTG-1:0]     s_vld_out;
    logic [NSTG*DW-1:0]  s_dat_out;
    logic                vld_out;
    logic [DW-1:0]       dat_out;
    logic                busy;
    logic [1:0]          state;

    logic [NSTG-1:0]     ph, mdl_vld, inj;
    logic [NSTG*DW-1:0]  mdl_dat;

    int total = 0;
    int bad   = 0;
    int nout, d0_zero, d0_hit;
    logic [NSTG-1:0] vin_or, snap_vin;
    logic [DW-1:0]   snap_d0;

    hb_chain_ctrl #(.DW(DW), .NSTG(NSTG), .FLUSH_LEN(64)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .cfg_en     (cfg_en),
        .cfg_nstage (cfg_nstage),
        .cfg_settle (cfg_settle),
        .cic_vld    (cic_vld),
        .cic_dat    (cic_dat),
        .s_vld_in   (s_vld_in),
        .s_dat_in   (s_dat_in),
        .s_vld_out  (s_vld_out),
        .s_dat_out  (s_dat_out),
        .vld_out    (vld_out),
        .dat_out    (dat_out),
        .busy       (busy),
        .state      (state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stage model: one-cycle latency, emits every second input sample unchanged.
    assign s_vld_out = mdl_vld | inj;
    assign s_dat_out = mdl_dat;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ph      <= '0;
            mdl_vld <= '0;
            mdl_dat <= '0;
        end else begin
            for (int k = 0; k < NSTG; k++) begin
                mdl_vld[k] <= s_vld_in[k] && ph[k];
                if (s_vld_in[k]) begin
                    ph[k] <= ~ph[k];
                    if (ph[k]) mdl_dat[k*DW +: DW] <= s_dat_in[k*DW +: DW];
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        nout = 0; d0_zero = 0; d0_hit = 0; vin_or = '0;
    endtask

    // One clock: drive at edge+1, snapshot combinational routing, sample registers after edge.
    task automatic step(input logic v, input logic [DW-1:0] d);
        cic_vld = v;
        cic_dat = d;
        #1;
        snap_vin = s_vld_in;
        snap_d0  = s_dat_in[DW-1:0];
        vin_or   = vin_or | snap_vin;
        if (v && snap_d0 == '0) d0_zero++;
        if (v && snap_d0 == 35'h7FF) d0_hit++;
        @(posedge clk);
        #1;
        cic_vld = 1'b0;
        inj = '0;
        if (vld_out) nout++;
    endtask

    initial begin
        rstn = 1'b0; cfg_en = 1'b0; cfg_nstage = 2'd0; cfg_settle = 8'd0;
        cic_vld = 1'b0; cic_dat = '0; inj = '0;
        clr();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_vld", 64'(vld_out), 64'd0);
        chk("rst_dat", 64'(dat_out), 64'd0);
        rstn = 1'b1;

        // bypass: n = 0
        cfg_en = 1'b1; cfg_nstage = 2'd0; cfg_settle = 8'd0;
        step(1'b0, '0);
        chk("byp_state", 64'(state), 64'd3);
        clr();
        step(1'b1, 35'd100);
        chk("byp_vld1", 64'(vld_out), 64'd1);
        chk("byp_dat1", 64'(dat_out), 64'd100);
        step(1'b0, 35'd100);
        chk("byp_vld0", 64'(vld_out), 64'd0);
        chk("byp_hold", 64'(dat_out), 64'd100);
        step(1'b1, 35'd100);
        chk("byp_vin", 64'(vin_or), 64'd0);
        chk("byp_vld2", 64'(vld_out), 64'd1);
        rstn = 1'b0;
        #1;
        chk("arst_vld", 64'(vld_out), 64'd0);
        chk("arst_dat", 64'(dat_out), 64'd0);
        chk("arst_state", 64'(state), 64'd0);
        cfg_en = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // flush, n = 1, settle = 0; strobe on IDLE->FLUSH cycle is not counted
        cfg_en = 1'b1; cfg_nstage = 2'd1; cfg_settle = 8'd0;
        clr();
        step(1'b1, 35'h7FF);
        chk("idle_vin", 64'(vin_or), 64'd0);
        chk("fl1_state", 64'(state), 64'd1);
        clr();
        for (int j = 1; j <= 63; j++) step(1'b1, 35'h7FF);
        chk("fl1_st63", 64'(state), 64'd1);
        step(1'b1, 35'h7FF);
        chk("fl1_st64", 64'(state), 64'd3);
        chk("fl1_zero", 64'(d0_zero), 64'd64);
        step(1'b0, '0);
        chk("fl1_tail_vld", 64'(vld_out), 64'd1);
        chk("fl1_tail_dat", 64'(dat_out), 64'd0);
        clr();
        for (int j = 0; j < 8; j++) step(1'b1, 35'h7FF);
        step(1'b0, '0);
        step(1'b0, '0);
        chk("run1_d0", 64'(d0_hit), 64'd8);
        chk("run1_rate", 64'(nout), 64'd4);
        chk("run1_dat", 64'(dat_out), 64'h7FF);
        chk("run1_vin21", 64'(vin_or[2:1]), 64'd0);

        // settle, n = 3, settle = 5
        cfg_en = 1'b0;
        step(1'b0, '0);
        chk("stop1_state", 64'(state), 64'd0);
        cfg_en = 1'b1; cfg_nstage = 2'd3; cfg_settle = 8'd5;
        step(1'b0, '0);
        chk("fl3_state", 64'(state), 64'd1);
        clr();
        for (int j = 1; j <= 64; j++) step(1'b1, 35'(1000 + j));
        chk("fl3_settle", 64'(state), 64'd2);
        for (int j = 65; j <= 104; j++) begin
            step(1'b1, 35'(1000 + j));
            if (j == 98) chk("set_st98", 64'(state), 64'd2);
            if (j == 99) chk("set_st99", 64'(state), 64'd3);
        end
        chk("set_discard", 64'(nout), 64'd0);
        repeat (4) step(1'b0, '0);
        chk("set_first", 64'(nout), 64'd1);
        chk("set_first_dat", 64'(dat_out), 64'd1104);
        for (int j = 105; j <= 120; j++) step(1'b1, 35'(1000 + j));
        repeat (4) step(1'b0, '0);
        chk("run3_rate", 64'(nout), 64'd3);
        chk("run3_dat", 64'(dat_out), 64'd1120);

        // config change while busy: run with n = 1, then request n = 2
        cfg_en = 1'b0;
        step(1'b0, '0);
        cfg_en = 1'b1; cfg_nstage = 2'd1; cfg_settle = 8'd0;
        step(1'b0, '0);
        for (int j = 0; j < 64; j++) step(1'b1, 35'd7);
        step(1'b0, '0);
        cfg_nstage = 2'd2;
        clr();
        for (int j = 0; j < 8; j++) step(1'b1, 35'(2000 + j));
        step(1'b0, '0);
        step(1'b0, '0);
        chk("cfg_hold_rate", 64'(nout), 64'd4);
        chk("cfg_hold_vin", 64'(vin_or[2:1]), 64'd0);
        inj = 3'b110;
        step(1'b0, '0);
        step(1'b0, '0);
        chk("ignore_hi_stg", 64'(nout), 64'd4);
        cfg_en = 1'b0;
        step(1'b0, '0);
        cfg_en = 1'b1;
        step(1'b0, '0);
        for (int j = 0; j < 64; j++) step(1'b1, 35'd9);
        step(1'b0, '0);
        step(1'b0, '0);
        clr();
        for (int j = 0; j < 16; j++) step(1'b1, 35'(3000 + j));
        repeat (3) step(1'b0, '0);
        chk("n2_rate", 64'(nout), 64'd4);
        chk("n2_dat", 64'(dat_out), 64'd3015);

        // stop mid-SETTLE on the strobe that would have ended settling
        cfg_en = 1'b0;
        step(1'b0, '0);
        cfg_en = 1'b1; cfg_nstage = 2'd1; cfg_settle = 8'd2;
        step(1'b0, '0);
        for (int j = 0; j < 64; j++) step(1'b1, 35'd5);
        chk("st5_settle", 64'(state), 64'd2);
        step(1'b0, '0);
        step(1'b1, 35'd11);
        step(1'b1, 35'd12);
        chk("st5_pre", 64'(state), 64'd2);
        cfg_en = 1'b0;
        clr();
        step(1'b0, '0);
        chk("st5_state", 64'(state), 64'd0);
        chk("st5_busy", 64'(busy), 64'd0);
        chk("st5_vld", 64'(vld_out), 64'd0);
        for (int j = 0; j < 6; j++) step(1'b1, 35'd13);
        chk("st5_vin", 64'(vin_or), 64'd0);
        chk("st5_nout", 64'(nout), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hb_chain_ctrl.md
Name: hb_chain_ctrl

Overview:
- Sequencer and router for the half-band decimation cascade behind the CIC: up to three HB stages, each decimating by 2, and each using the 35-bit signed data / one-cycle valid-strobe interface.
- Gates the valid strobes into the cascade and routes each stage's output to the next stage's input.
- On start, flushes the filter delay lines with zeros, then discards a programmable number of settling outputs.
- Muxes the output of the last active stage onto a single registered output.

Parameters:
- DW, 35, sample width (signed) on every data port.
- NSTG, 3, number of physical HB stages attached.
- FLUSH_LEN, 64, number of zero input samples pushed into stage 0 during FLUSH; must be even and >= 2^NSTG*6.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- cfg_en  in  1  level; 1 = run cascade, 0 = stop and return to IDLE
- cfg_nstage  in  2  active stages 0..3 (0 = bypass); sampled only on IDLE->FLUSH
- cfg_settle  in  8  final-stage outputs to discard after flush; sampled with cfg_nstage
- cic_vld  in  1  input sample strobe from CIC
- cic_dat  in  DW  input sample, signed
- s_vld_in  out  NSTG  valid strobe into stage k (combinational)
- s_dat_in  out  NSTG*DW  data into stage k, stage k at bits [k*DW +: DW] (combinational)
- s_vld_out  in  NSTG  valid strobe from stage k
- s_dat_out  in  NSTG*DW  data from stage k, same packing
- vld_out  out  1  output strobe, registered
- dat_out  out  DW  output sample, registered, signed
- busy  out  1  state != IDLE
- state  out  2  00 IDLE, 01 FLUSH, 10 SETTLE, 11 RUN

Behaviour:
- Reset values: state = IDLE, vld_out = 0, dat_out = 0, busy = 0, flush and settle counters = 0, latched config = 0.
- All outputs take their reset values immediately on rstn low, including in the middle of any operation.
- Latched config: n = cfg_nstage and settle = cfg_settle, captured on the IDLE->FLUSH transition. Changes to the config inputs while busy are ignored.

State machine:
- IDLE: if cfg_en = 1, latch config, clear counters, go to FLUSH. If n = 0, go directly to RUN instead (bypass needs no flush).
- FLUSH: each cic_vld increments the flush counter. The cycle in which the counter reaches FLUSH_LEN goes to SETTLE; if settle = 0, go to RUN instead.
- SETTLE: each final-stage strobe increments the settle counter. The strobe on which the counter reaches settle goes to RUN. Discarded strobes never assert vld_out.
- RUN: remain until cfg_en = 0.
- cfg_en = 0 in any non-IDLE state goes to IDLE on the next clock and has priority over all other transitions. The in-flight strobe in that cycle still follows the routing rules for the current state.

Routing (combinational, every state):
- act[k] = (state != IDLE) && (k < n).
- s_vld_in[0] = cic_vld && act[0]; s_dat_in[0] = (state == FLUSH) ? 0 : cic_dat.
- For k >= 1: s_vld_in[k] = s_vld_out[k-1] && act[k]; s_dat_in[k] = s_dat_out[k-1].
- Inactive stages receive no strobes, so their delay lines freeze.
- Final strobe/data: for n = 0, cic_vld and cic_dat; otherwise s_vld_out[n-1] and s_dat_out[n-1].

Output:
- In RUN, on a final strobe: vld_out <= 1 and dat_out <= final data. Latency is one clk from the final strobe.
- In all other cycles vld_out <= 0 and dat_out holds its value.
- The output rate is exactly cic_vld rate / 2^n. No data modification occurs.

Boundary conditions:
- cic_vld present in the IDLE->FLUSH cycle: that sample is not counted and not forwarded, because act = 0 in IDLE.
- cic_vld present in the FLUSH->SETTLE cycle: forwarded as zero and counted as the last flush sample.
- A final strobe in the same cycle as SETTLE->RUN is discarded. The first delivered sample is the next strobe.
- s_vld_out strobes arriving from stages >= n are ignored.

Test Plan:
- Reset, bypass: rstn low mid-RUN -> vld_out = 0, dat_out = 0, state = 00 in the same cycle.
  - Then cfg_en = 1, n = 0, cic_dat = 100 on every strobe -> state goes 00->11 in one clock; vld_out follows cic_vld one clock late with dat_out = 100; s_vld_in = 000.
- Flush, n = 1, settle = 0: 64 strobes with cic_dat = 0x7FF -> s_dat_in[0] = 0 for all 64 and the state leaves FLUSH on the 64th.
  - Thereafter s_dat_in[0] = 0x7FF; vld_out pulses once per 2 cic_vld; s_vld_in[2:1] = 00.
- Settle, n = 3, settle = 5 with stage models: the first 5 s_vld_out[2] pulses after FLUSH give no vld_out.
  - The 6th gives vld_out with dat_out = s_dat_out[2]; output rate = cic_vld/8.
- Config change while busy: n = 2 while RUN entered with n = 1 -> routing unchanged (stage 1 gets no strobes) until cfg_en 0->1; after the re-start, rate = cic_vld/4.
- Stop mid-SETTLE: cfg_en = 0 on the same cycle as a final strobe -> next state IDLE, no vld_out, busy = 0, s_vld_in = 000 thereafter.
- Boundary strobes: cic_vld on the IDLE->FLUSH cycle is not counted (FLUSH still takes 64 further strobes).
  - Final strobe on the SETTLE->RUN cycle is discarded; the first vld_out comes on the next strobe.
